// File: rtl/ula_operand_loader_pkg.sv
// Shared widths, FSM state encoding and ULA opcode constants for the operand loader.
package ula_operand_loader_pkg;
   localparam int WIDTH = 6;
   localparam int SEL_W = 4;

   typedef enum logic [2:0] {
      ST_A    = 3'd0,
      ST_B    = 3'd1,
      ST_S    = 3'd2,
      ST_EXEC = 3'd3,
      ST_SHOW = 3'd4
   } state_t;

   localparam logic [SEL_W-1:0] OP_ADD  = 4'b0000;
   localparam logic [SEL_W-1:0] OP_SUB  = 4'b0001;
   localparam logic [SEL_W-1:0] OP_ADDN = 4'b0010;
   localparam logic [SEL_W-1:0] OP_SUBN = 4'b0011;
   localparam logic [SEL_W-1:0] OP_INCA = 4'b0100;
   localparam logic [SEL_W-1:0] OP_DECA = 4'b0101;
   localparam logic [SEL_W-1:0] OP_INCB = 4'b0110;
   localparam logic [SEL_W-1:0] OP_DECB = 4'b0111;
endpackage

// File: rtl/ula_operand_loader_if.sv
// Bundle of entry-bus, ULA-facing and status signals between the loader and its surroundings.
interface ula_operand_loader_if
   #(parameter int WIDTH = ula_operand_loader_pkg::WIDTH,
     parameter int SEL_W = ula_operand_loader_pkg::SEL_W);
   logic [WIDTH-1:0] data_in;
   logic             load;
   logic             chain;
   logic             clear;
   logic [WIDTH-1:0] ula_O;
   logic             ula_carry;
   logic             ula_zero;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic [SEL_W-1:0] S;
   logic [WIDTH-1:0] res_q;
   logic             carry_q;
   logic             zero_q;
   logic             valid;
   logic [2:0]       state_o;

   modport master (
      output data_in, load, chain, clear, ula_O, ula_carry, ula_zero,
      input  A, B, S, res_q, carry_q, zero_q, valid, state_o
   );

   modport slave (
      input  data_in, load, chain, clear, ula_O, ula_carry, ula_zero,
      output A, B, S, res_q, carry_q, zero_q, valid, state_o
   );
endinterface

// File: rtl/ula_operand_loader_rise_detect.sv
// Registered rising-edge detector: a level held for many cycles yields a single pulse.
module ula_operand_loader_rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic d_i,
   output logic rise_o
);
   logic d_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     d_q <= 1'b0;
      else if (clr_i) d_q <= 1'b0;
      else            d_q <= d_i;
   end

   assign rise_o = d_i & ~d_q;
endmodule

// File: rtl/ula_operand_loader.sv
// Collects A, B and S from the shared entry bus, drives the ULA and captures its result and flags.
module ula_operand_loader
   #(parameter int WIDTH = ula_operand_loader_pkg::WIDTH,
     parameter int SEL_W = ula_operand_loader_pkg::SEL_W)
   (
   input logic                 clk,
   input logic                 rst_n,
   ula_operand_loader_if.slave bus
);
   import ula_operand_loader_pkg::*;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [SEL_W-1:0] s_q, s_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             cy_q, cy_d;
   logic             zf_q, zf_d;
   logic             load_rise;

   ula_operand_loader_rise_detect u_rise (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (bus.clear),
      .d_i    (bus.load),
      .rise_o (load_rise)
   );

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      s_d      = s_q;
      result_d = result_q;
      cy_d     = cy_q;
      zf_d     = zf_q;

      case (state_q)
         ST_A: if (load_rise) begin
            a_d     = bus.data_in;
            state_d = ST_B;
         end
         ST_B: if (load_rise) begin
            b_d     = bus.data_in;
            state_d = ST_S;
         end
         ST_S: if (load_rise) begin
            s_d     = bus.data_in[SEL_W-1:0];
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            result_d = bus.ula_O;
            cy_d     = bus.ula_carry;
            zf_d     = bus.ula_zero;
            state_d  = ST_SHOW;
         end
         ST_SHOW: if (load_rise) begin
            // chain only matters here: the shown result becomes the next A
            a_d     = bus.chain ? result_q : bus.data_in;
            state_d = ST_B;
         end
         default: state_d = ST_A;
      endcase

      if (bus.clear) begin
         state_d  = ST_A;
         a_d      = '0;
         b_d      = '0;
         s_d      = '0;
         result_d = '0;
         cy_d     = 1'b0;
         zf_d     = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_A;
         a_q      <= '0;
         b_q      <= '0;
         s_q      <= '0;
         result_q <= '0;
         cy_q     <= 1'b0;
         zf_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         s_q      <= s_d;
         result_q <= result_d;
         cy_q     <= cy_d;
         zf_q     <= zf_d;
      end
   end

   assign bus.A       = a_q;
   assign bus.B       = b_q;
   assign bus.S       = s_q;
   assign bus.res_q   = result_q;
   assign bus.carry_q = cy_q;
   assign bus.zero_q  = zf_q;
   assign bus.valid   = (state_q == ST_SHOW);
   assign bus.state_o = state_q;
endmodule

// File: tb/tb_ula_operand_loader.sv
// Directed bench: loader plus a behavioural 6-bit ULA, checked against hand-computed values.
module tb_ula_operand_loader;
   import ula_operand_loader_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   checks = 0;
   int   failures = 0;

   ula_operand_loader_if bus ();

   ula_operand_loader #(.WIDTH(6), .SEL_W(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Behavioural ULA: carry is carry-out for additions, no-borrow for subtractions.
   logic [6:0] ula_wide;
   always_comb begin
      ula_wide = '0;
      case (bus.S)
         OP_ADD:  ula_wide = {1'b0, bus.A} + {1'b0, bus.B};
         OP_SUB:  ula_wide = {1'b0, bus.A} + {1'b0, ~bus.B} + 7'd1;
         OP_ADDN: ula_wide = {1'b0, ~bus.A} + {1'b0, bus.B};
         OP_SUBN: ula_wide = {1'b0, bus.B} + {1'b0, ~bus.A} + 7'd1;
         OP_INCA: ula_wide = {1'b0, bus.A} + 7'd1;
         OP_DECA: ula_wide = {1'b0, bus.A} + 7'h3F;
         OP_INCB: ula_wide = {1'b0, bus.B} + 7'd1;
         OP_DECB: ula_wide = {1'b0, bus.B} + 7'h3F;
         default: ula_wide = '0;
      endcase
      bus.ula_O     = ula_wide[5:0];
      bus.ula_carry = ula_wide[6];
      bus.ula_zero  = (bus.S[3] == 1'b0) && (ula_wide[5:0] == 6'd0);
   end

   task automatic do_load(input logic [5:0] v);
      @(negedge clk);
      bus.data_in = v;
      bus.load    = 1'b1;
      @(negedge clk);
      bus.load    = 1'b0;
   endtask

   task automatic test_reset;
      #1;
      checks++;
      if ({bus.A, bus.B, bus.S, bus.res_q, bus.carry_q, bus.zero_q, bus.valid, bus.state_o} !== '0) begin
         failures++;
         $display("FAIL reset_held A=%0d B=%0d S=%0d res=%0d c=%0b z=%0b v=%0b st=%0d exp all 0",
                  bus.A, bus.B, bus.S, bus.res_q, bus.carry_q, bus.zero_q, bus.valid, bus.state_o);
      end
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.A, bus.B, bus.S, bus.res_q, bus.valid, bus.state_o} !== '0) begin
         failures++;
         $display("FAIL reset_release A=%0d st=%0d v=%0b exp all 0", bus.A, bus.state_o, bus.valid);
      end
   endtask

   task automatic test_basic_add;
      do_load(6'd5);
      checks++;
      if (bus.A !== 6'd5 || bus.state_o !== 3'd1) begin
         failures++;
         $display("FAIL load_a A=%0d st=%0d exp A=5 st=1", bus.A, bus.state_o);
      end
      do_load(6'd3);
      checks++;
      if (bus.B !== 6'd3 || bus.state_o !== 3'd2) begin
         failures++;
         $display("FAIL load_b B=%0d st=%0d exp B=3 st=2", bus.B, bus.state_o);
      end
      do_load(6'd0);
      checks++;
      if (bus.S !== 4'd0 || bus.state_o !== 3'd3 || bus.valid !== 1'b0) begin
         failures++;
         $display("FAIL load_s S=%0d st=%0d v=%0b exp S=0 st=3 v=0", bus.S, bus.state_o, bus.valid);
      end
      @(negedge clk);
      checks++;
      if (bus.res_q !== 6'd8 || bus.carry_q !== 1'b0 || bus.zero_q !== 1'b0 ||
          bus.valid !== 1'b1 || bus.state_o !== 3'd4) begin
         failures++;
         $display("FAIL add_result res=%0d c=%0b z=%0b v=%0b st=%0d exp 8 0 0 1 4",
                  bus.res_q, bus.carry_q, bus.zero_q, bus.valid, bus.state_o);
      end
   endtask

   task automatic test_chain;
      bus.chain = 1'b1;
      do_load(6'd17);
      bus.chain = 1'b0;
      checks++;
      if (bus.A !== 6'd8 || bus.state_o !== 3'd1 || bus.valid !== 1'b0) begin
         failures++;
         $display("FAIL chain_a A=%0d st=%0d v=%0b exp A=8 st=1 v=0", bus.A, bus.state_o, bus.valid);
      end
      do_load(6'd8);
      do_load(6'b110001);
      checks++;
      if (bus.S !== 4'b0001) begin
         failures++;
         $display("FAIL sel_upper_ignored S=%0d exp 1", bus.S);
      end
      @(negedge clk);
      checks++;
      if (bus.res_q !== 6'd0 || bus.carry_q !== 1'b1 || bus.zero_q !== 1'b1 || bus.valid !== 1'b1) begin
         failures++;
         $display("FAIL chain_sub res=%0d c=%0b z=%0b v=%0b exp 0 1 1 1",
                  bus.res_q, bus.carry_q, bus.zero_q, bus.valid);
      end
   endtask

   task automatic test_wrap;
      do_load(6'd63);
      do_load(6'd1);
      do_load(6'd0);
      @(negedge clk);
      checks++;
      if (bus.res_q !== 6'd0 || bus.carry_q !== 1'b1 || bus.zero_q !== 1'b1) begin
         failures++;
         $display("FAIL wrap_add res=%0d c=%0b z=%0b exp 0 1 1", bus.res_q, bus.carry_q, bus.zero_q);
      end
      do_load(6'd0);
      do_load(6'd9);
      do_load(6'd5);
      @(negedge clk);
      checks++;
      if (bus.res_q !== 6'd63 || bus.carry_q !== 1'b0 || bus.zero_q !== 1'b0) begin
         failures++;
         $display("FAIL wrap_deca res=%0d c=%0b z=%0b exp 63 0 0", bus.res_q, bus.carry_q, bus.zero_q);
      end
   endtask

   task automatic test_held_load;
      @(negedge clk);
      bus.clear = 1'b1;
      @(negedge clk);
      bus.clear = 1'b0;
      bus.data_in = 6'd21;
      bus.load    = 1'b1;
      @(negedge clk);
      bus.data_in = 6'd22;
      repeat (9) @(negedge clk);
      checks++;
      if (bus.A !== 6'd21 || bus.state_o !== 3'd1) begin
         failures++;
         $display("FAIL held_load A=%0d st=%0d exp A=21 st=1", bus.A, bus.state_o);
      end
      bus.load = 1'b0;
      do_load(6'd2);
      do_load(6'd0);
      bus.data_in = 6'd7;
      bus.load    = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.state_o !== 3'd4 || bus.res_q !== 6'd23 || bus.A !== 6'd21 || bus.B !== 6'd2) begin
         failures++;
         $display("FAIL exec_ignores_load st=%0d res=%0d A=%0d B=%0d exp 4 23 21 2",
                  bus.state_o, bus.res_q, bus.A, bus.B);
      end
      @(negedge clk);
      bus.load = 1'b0;
      checks++;
      if (bus.state_o !== 3'd4 || bus.valid !== 1'b1) begin
         failures++;
         $display("FAIL show_no_rise st=%0d v=%0b exp 4 1", bus.state_o, bus.valid);
      end
   endtask

   task automatic test_clear_reset;
      do_load(6'd1);
      do_load(6'd2);
      @(negedge clk);
      bus.clear   = 1'b1;
      bus.load    = 1'b1;
      bus.data_in = 6'd3;
      @(negedge clk);
      bus.clear = 1'b0;
      bus.load  = 1'b0;
      checks++;
      if ({bus.A, bus.B, bus.S, bus.res_q, bus.carry_q, bus.zero_q, bus.valid, bus.state_o} !== '0) begin
         failures++;
         $display("FAIL clear_over_load A=%0d B=%0d S=%0d res=%0d st=%0d exp all 0",
                  bus.A, bus.B, bus.S, bus.res_q, bus.state_o);
      end
      do_load(6'd4);
      do_load(6'd5);
      do_load(6'd0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.A, bus.B, bus.S, bus.res_q, bus.valid, bus.state_o} !== '0) begin
         failures++;
         $display("FAIL async_reset_exec A=%0d B=%0d st=%0d exp all 0", bus.A, bus.B, bus.state_o);
      end
      @(negedge clk);
      checks++;
      if ({bus.res_q, bus.carry_q, bus.zero_q, bus.valid, bus.state_o} !== '0) begin
         failures++;
         $display("FAIL reset_hold res=%0d st=%0d exp 0 0", bus.res_q, bus.state_o);
      end
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.state_o !== 3'd0 || bus.A !== 6'd0) begin
         failures++;
         $display("FAIL post_reset st=%0d A=%0d exp 0 0", bus.state_o, bus.A);
      end
   endtask

   initial begin
      bus.data_in = '0;
      bus.load    = 1'b0;
      bus.chain   = 1'b0;
      bus.clear   = 1'b0;
      test_reset();
      test_basic_add();
      test_chain();
      test_wrap();
      test_held_load();
      test_clear_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end
endmodule
